// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Four-state instruction sequencer driving an external ALU from an
//             8 x 16-bit register file, with writeback and error reporting.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
   parameter int NREGS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_ctrl,
   input  logic [15:0] alu_result,
   output logic        done,
   output logic [1:0]  err,
   output logic        zero,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   localparam logic [1:0] c_ERR_OK      = 2'b00;
   localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] c_ERR_DIVZERO = 2'b10;
   localparam logic [2:0] c_CTRL_DIV    = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DECODE    = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   state_t      r_state;
   logic [3:0]  r_op;
   logic [2:0]  r_rd;
   logic [2:0]  r_rs1;
   logic [2:0]  r_rs2;
   logic [15:0] r_alu_a;
   logic [15:0] r_alu_b;
   logic [2:0]  r_alu_ctrl;
   logic [15:0] r_result;
   logic        r_done;
   logic [1:0]  r_err;
   logic        r_zero;
   logic [15:0] r_regs [NREGS];

   logic        w_legal;
   logic        w_div_zero;
   logic        w_unused_instr;

   assign w_legal        = (r_op < 4'd6);
   assign w_div_zero     = (r_alu_ctrl == c_CTRL_DIV) && (r_alu_b == 16'h0000);
   assign w_unused_instr = ^instr[2:0];

   assign instr_ready = (r_state == S_IDLE);
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_ctrl    = r_alu_ctrl;
   assign done        = r_done;
   assign err         = r_err;
   assign zero        = r_zero;
   // R0 is never written, so a plain read returns 0 for index 0.
   assign dbg_data    = r_regs[dbg_addr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_op       <= 4'd0;
         r_rd       <= 3'd0;
         r_rs1      <= 3'd0;
         r_rs2      <= 3'd0;
         r_alu_a    <= 16'h0000;
         r_alu_b    <= 16'h0000;
         r_alu_ctrl <= 3'b000;
         r_result   <= 16'h0000;
         r_done     <= 1'b0;
         r_err      <= c_ERR_OK;
         r_zero     <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= 16'h0000;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op    <= instr[15:12];
                  r_rd    <= instr[11:9];
                  r_rs1   <= instr[8:6];
                  r_rs2   <= instr[5:3];
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_alu_a <= r_regs[r_rs1];
               r_alu_b <= r_regs[r_rs2];
               if (w_legal) begin
                  r_alu_ctrl <= r_op[2:0];
                  r_state    <= S_EXECUTE;
               end else begin
                  // Illegal opcodes skip the ALU and retire one cycle early.
                  r_alu_ctrl <= 3'b000;
                  r_err      <= c_ERR_ILLEGAL;
                  r_done     <= 1'b1;
                  r_state    <= S_WRITEBACK;
               end
            end
            S_EXECUTE: begin
               r_result <= alu_result;
               r_done   <= 1'b1;
               r_state  <= S_WRITEBACK;
               if (w_div_zero) begin
                  r_err <= c_ERR_DIVZERO;
               end else begin
                  r_err  <= c_ERR_OK;
                  r_zero <= (alu_result == 16'h0000);
               end
            end
            S_WRITEBACK: begin
               if ((r_err == c_ERR_OK) && (r_rd != 3'd0)) begin
                  r_regs[r_rd] <= r_result;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Scoreboard bench for alu_op_sequencer with an ALU stub and a
//             behavioural register-file model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        instr_ready;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_ctrl;
   logic [15:0] alu_result;
   logic        done;
   logic [1:0]  err;
   logic        zero;
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;

   typedef struct packed {
      logic [1:0] err;
      logic       zero;
      logic [2:0] ctrl;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_regs [8];
   logic        m_zero;
   logic        inj_en  = 1'b0;
   logic [15:0] inj_val = 16'h0000;
   int          n_vec   = 0;
   int          n_fail  = 0;

   alu_op_sequencer #(.NREGS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_ready(instr_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .done       (done),
      .err        (err),
      .zero       (zero),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   // External ALU stub; inj_en lets the bench force a result to seed registers.
   always_comb begin
      alu_result = 16'h0000;
      if (inj_en) begin
         alu_result = inj_val;
      end else begin
         case (alu_ctrl)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a * alu_b;
            3'd5: alu_result = (alu_b == 16'h0000) ? 16'hFFFF : alu_a / alu_b;
            default: alu_result = 16'h0000;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
      return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
   endfunction

   // Reference model: applies one instruction, pushes the expected retirement, returns latency.
   function automatic int model_apply(input logic [15:0] ins);
      int          op, rd;
      logic [15:0] a, b, res;
      exp_t        e;
      op = int'(ins[15:12]);
      rd = int'(ins[11:9]);
      a  = m_regs[ins[8:6]];
      b  = m_regs[ins[5:3]];
      if (op > 5) begin
         e = '{err: 2'b01, zero: m_zero, ctrl: 3'b000};
         sb_q.push_back(e);
         return 2;
      end
      e.ctrl = op[2:0];
      if (op == 5 && b == 16'h0000) begin
         e.err  = 2'b10;
         e.zero = m_zero;
      end else begin
         case (op)
            0:       res = a + b;
            1:       res = a - b;
            2:       res = a & b;
            3:       res = a | b;
            4:       res = 16'((32'(a) * 32'(b)) % 65536);
            default: res = a / b;
         endcase
         if (inj_en) res = inj_val;
         e.err  = 2'b00;
         m_zero = (res == 16'h0000);
         e.zero = m_zero;
         if (rd != 0) m_regs[rd] = res;
      end
      sb_q.push_back(e);
      return 3;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst && done) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_pulse: got 1 expected 0 (no instruction pending)");
         end else begin
            e = sb_q.pop_front();
            chk("err", 32'(err), 32'(e.err));
            chk("zero", 32'(zero), 32'(e.zero));
            chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
         end
      end
   end

   task automatic issue(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
      int lat_exp, lat, w;
      w = 0;
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) begin
         chk("ready_timeout", 32'(instr_ready), 32'd1);
         return;
      end
      instr_valid = 1'b1;
      instr       = ins;
      lat_exp     = model_apply(ins);
      @(posedge clk);
      #1;
      if (hold) instr = nxt;
      else      instr_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         chk("ready_busy", 32'(instr_ready), 32'd0);
      end while (!done && lat < 8);
      chk("latency", 32'(lat), 32'(lat_exp));
   endtask

   task automatic check_regs();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk($sformatf("R%0d", i), 32'(dbg_data), 32'(m_regs[i]));
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sb_q.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_zero = 1'b0;
      #1;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(instr_ready), 32'd1);
   endtask

   initial begin
      int op;
      @(negedge clk);
      do_reset();

      issue(mk(0, 1, 0, 0), 1'b0, 16'h0);
      inj_en = 1'b1;
      inj_val = 16'd7;
      issue(mk(0, 2, 0, 0), 1'b0, 16'h0);
      inj_val = 16'd5;
      issue(mk(0, 3, 0, 0), 1'b0, 16'h0);
      inj_en = 1'b0;
      issue(mk(1, 4, 2, 3), 1'b0, 16'h0);
      issue(mk(4, 5, 2, 3), 1'b0, 16'h0);
      issue(mk(5, 6, 2, 0), 1'b0, 16'h0);
      issue(mk(15, 2, 3, 4), 1'b0, 16'h0);
      // Back-to-back with instr_valid held: the second reads the first's result.
      issue(mk(0, 7, 2, 3), 1'b1, mk(1, 1, 7, 2));
      issue(mk(1, 1, 7, 2), 1'b0, 16'h0);
      @(negedge clk);
      check_regs();
      dbg_addr = 3'd4;
      #1;
      chk("R4_sub", 32'(dbg_data), 32'd2);
      dbg_addr = 3'd5;
      #1;
      chk("R5_mul", 32'(dbg_data), 32'h0023);
      dbg_addr = 3'd1;
      #1;
      chk("R1_chain", 32'(dbg_data), 32'd5);

      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 15));
         inj_en  = ($urandom_range(0, 2) == 0);
         inj_val = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         issue(mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7))), 1'b0, 16'h0);
         inj_en = 1'b0;
      end
      @(negedge clk);
      check_regs();

      inj_en = 1'b1;
      inj_val = 16'd3;
      issue(mk(0, 2, 0, 0), 1'b0, 16'h0);
      inj_val = 16'd4;
      issue(mk(0, 3, 0, 0), 1'b0, 16'h0);
      inj_en = 1'b0;
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = mk(0, 1, 2, 3);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("in_execute_ctrl", 32'(alu_ctrl), 32'd0);
      chk("in_execute_a", 32'(alu_a), 32'd3);
      do_reset();
      repeat (5) @(negedge clk);
      check_regs();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning the number of 16-bit registers in the internal register file; the value is fixed at 8 and is addressed by a 3-bit field.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port instr_valid, input, 1, meaning the instruction word on instr is offered.
REQ-005 SHALL have port instr, input, 16, the instruction word: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
REQ-006 SHALL have port instr_ready, output, 1, meaning the sequencer accepts an instruction this cycle.
REQ-007 SHALL have port alu_a, output, 16, the operand A driven to the external ALU.
REQ-008 SHALL have port alu_b, output, 16, the operand B driven to the external ALU.
REQ-009 SHALL have port alu_ctrl, output, 3, the ALUControl code driven to the external ALU.
REQ-010 SHALL have port alu_result, input, 16, the combinational Result returned by the external ALU.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse marking instruction retirement.
REQ-012 SHALL have port err, output, 2: 00 ok, 01 illegal opcode, 10 divide by zero; valid while done=1.
REQ-013 SHALL have port zero, output, 1, meaning the last written-back result was 16'h0000.
REQ-014 SHALL have port dbg_addr, input, 3, the debug read register index.
REQ-015 SHALL have port dbg_data, output, 16, the combinational read of register dbg_addr.

Function
REQ-016 SHALL implement the FSM states IDLE, DECODE, EXECUTE, WRITEBACK.
REQ-017 SHALL assert instr_ready only in IDLE; a transfer occurs when instr_valid=1 and instr_ready=1, latching instr and moving to DECODE.
REQ-018 In DECODE, SHALL map the opcode as follows: 0 ADD->000, 1 SUB->001, 2 AND->010, 3 OR->011, 4 MUL->100, 5 DIV->101; opcodes 6-15 are illegal.
REQ-019 In DECODE, SHALL register alu_a=R[rs1], alu_b=R[rs2] and alu_ctrl; a legal opcode goes to EXECUTE.
REQ-020 In DECODE, an illegal opcode SHALL go directly to WRITEBACK with err=01, no register write, and alu_ctrl=000.
REQ-021 In EXECUTE, SHALL capture alu_result into an internal result register and go to WRITEBACK.
REQ-022 In EXECUTE, DIV with alu_b=0 SHALL set err=10 and suppress the register write.
REQ-023 In WRITEBACK, SHALL write the result to R[rd] if err=00 and rd!=0, update zero, pulse done for one cycle, and return to IDLE.
REQ-024 Latency from the accepting edge to done high SHALL be 3 cycles for legal ops and 2 cycles for illegal ops; throughput is 1 instruction per 4 or 3 cycles.
REQ-025 Register R0 SHALL always read 0; writes to R0 are dropped but still pulse done with err=00 and update zero from the result.
REQ-026 Arithmetic SHALL be performed by the external ALU only; the result is truncated to 16 bits, with no carry or overflow reporting.
REQ-027 The sources of the next instruction SHALL see the write of the previous instruction: the write completes in WRITEBACK, before the next IDLE acceptance.
REQ-028 instr_valid while not in IDLE SHALL be ignored and the instruction is not consumed.
REQ-029 err and zero SHALL hold their values until the next WRITEBACK; done is low except in WRITEBACK.

Reset
REQ-030 Asserting rst low at any time, including mid-instruction, SHALL immediately force: state IDLE, all registers 0, alu_a=alu_b=0, alu_ctrl=000, done=0, err=00, zero=0.
REQ-031 An instruction in flight at reset SHALL be discarded with no writeback and no done.
REQ-032 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 ADD: from reset, ADD r1,r0,r0 -> done at the 3rd cycle after acceptance, err=00, zero=1, R1=0.
REQ-034 Load via an arithmetic chain: preload R2=7 and R3=5 through a prior sequence, then SUB r4,r2,r3 -> alu_ctrl=001, R4=2; MUL r5,r2,r3 -> R5=35 (16'h0023).
REQ-035 DIV r6,r2,r0 -> err=10, R6 unchanged, done pulses once.
REQ-036 Opcode 4'hF -> done 2 cycles after acceptance, err=01, no register changes.
REQ-037 Back-to-back: instr_valid held high with two instructions -> second accepted only after done; the second instruction reads the first's rd result.
REQ-038 rst pulsed low during EXECUTE of ADD r1,r2,r3 -> no done; R1=0; instr_ready=1 after release.
